// File: rtl/packet_loader_pkg.sv
// Shared types and constants for the packet loader slice.
// Optional build macro: PKT_CSUM_CLEAR_EN (zero IPv4 checksum bytes).
package packet_loader_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [LEN_W-1:0]  pkt_len_t;

  localparam pkt_len_t CSUM_BYTE_OFS = 16'd24;

  typedef enum logic [1:0] {
    LDR_IDLE  = 2'd0,
    LDR_RECV  = 2'd1,
    LDR_START = 2'd2,
    LDR_WAIT  = 2'd3
  } ldr_state_t;

  function automatic logic is_csum_byte(pkt_len_t idx);
    return (idx == CSUM_BYTE_OFS) ||
           (idx == CSUM_BYTE_OFS + 16'd1);
  endfunction

endpackage

// File: rtl/packet_loader_if.sv
// Byte ingress stream plus SRAM write port of the packet loader.
// master = loader side, slave = MAC/SRAM side.
interface packet_loader_if;
  import packet_loader_pkg::*;

  logic       rx_valid_i;
  logic [7:0] rx_data_i;
  logic       rx_last_i;
  logic       rx_ready_o;

  logic       sram_ce_o;
  logic       sram_we_o;
  addr_t      sram_addr_o;
  logic [3:0] sram_sel_o;
  data_t      sram_data_o;

  modport master (
    input  rx_valid_i,
    input  rx_data_i,
    input  rx_last_i,
    output rx_ready_o,
    output sram_ce_o,
    output sram_we_o,
    output sram_addr_o,
    output sram_sel_o,
    output sram_data_o
  );

  modport slave (
    output rx_valid_i,
    output rx_data_i,
    output rx_last_i,
    input  rx_ready_o,
    input  sram_ce_o,
    input  sram_we_o,
    input  sram_addr_o,
    input  sram_sel_o,
    input  sram_data_o
  );

endinterface

// File: rtl/packet_loader_word_packer.sv
// Big-endian byte-to-word assembly with lane mask and flush on last.
// Emits one registered write per full word or final partial word.
module packet_loader_word_packer
  import packet_loader_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       flush,
  input  logic [7:0] din,
  output logic       emit,
  output logic       wr_en,
  output logic [3:0] wr_sel,
  output data_t      wr_data
);

  logic [1:0] lane;
  data_t      acc_q;
  data_t      acc_d;
  logic [3:0] fill_q;
  logic [3:0] fill_d;

  // ~lane selects byte lane 3-lane, so byte 0 lands in data[31:24]
  always_comb begin
    acc_d  = acc_q;
    fill_d = fill_q;
    if (push) begin
      acc_d[{~lane, 3'b000} +: 8] = din;
      fill_d[~lane]               = 1'b1;
    end
    emit = (push && lane == 2'd3) ||
           (flush && fill_d != 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane    <= 2'd0;
      acc_q   <= '0;
      fill_q  <= 4'd0;
      wr_en   <= 1'b0;
      wr_sel  <= 4'd0;
      wr_data <= '0;
    end else begin
      wr_en   <= emit;
      wr_sel  <= emit ? fill_d : 4'd0;
      wr_data <= emit ? acc_d : '0;
      if (clr || emit) begin
        lane   <= 2'd0;
        acc_q  <= '0;
        fill_q <= 4'd0;
      end else if (push) begin
        lane   <= lane + 2'd1;
        acc_q  <= acc_d;
        fill_q <= fill_d;
      end
    end
  end

endmodule

// File: rtl/packet_loader.sv
// Packs an ingress byte stream into the executor SRAM buffer, then starts it.
// Build macro PKT_CSUM_CLEAR_EN: store packet bytes 24..25 as zero.
module packet_loader
  import packet_loader_pkg::*;
#(
  parameter addr_t    BASE_ADDR = 32'd64,
  parameter pkt_len_t MAX_BYTES = 16'd1536
) (
  input  logic     clk,
  input  logic     rst,
  packet_loader_if.master bus,
  output logic     start_o,
  output addr_t    start_addr_o,
  output pkt_len_t pkt_len_o,
  output logic     trunc_o,
  input  logic     exec_done_i
);

  ldr_state_t state;
  pkt_len_t   byte_cnt;
  addr_t      word_addr;
  addr_t      wr_addr;
  logic       rx_ready;

  logic       acc;
  logic       keep;
  logic       push;
  logic       flush;
  logic       clr;
  logic [7:0] din;
  logic       emit;
  logic       wr_en;
  logic [3:0] wr_sel;
  data_t      wr_data;

  assign acc   = bus.rx_valid_i & rx_ready;
  assign keep  = byte_cnt < MAX_BYTES;
  assign push  = acc & keep;
  assign flush = acc & bus.rx_last_i;
  assign clr   = (state == LDR_IDLE);

`ifdef PKT_CSUM_CLEAR_EN
  // executor recomputes the IPv4 header checksum
  assign din = is_csum_byte(byte_cnt) ? 8'h00 : bus.rx_data_i;
`else
  assign din = bus.rx_data_i;
`endif

  packet_loader_word_packer u_packer (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr),
    .push    (push),
    .flush   (flush),
    .din     (din),
    .emit    (emit),
    .wr_en   (wr_en),
    .wr_sel  (wr_sel),
    .wr_data (wr_data)
  );

  assign bus.rx_ready_o  = rx_ready;
  assign bus.sram_ce_o   = wr_en;
  assign bus.sram_we_o   = wr_en;
  assign bus.sram_addr_o = wr_addr;
  assign bus.sram_sel_o  = wr_sel;
  assign bus.sram_data_o = wr_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= LDR_IDLE;
      rx_ready     <= 1'b0;
      byte_cnt     <= '0;
      word_addr    <= '0;
      wr_addr      <= '0;
      start_o      <= 1'b0;
      start_addr_o <= '0;
      pkt_len_o    <= '0;
      trunc_o      <= 1'b0;
    end else begin
      start_o <= 1'b0;
      wr_addr <= emit ? word_addr : '0;
      if (emit) begin
        word_addr <= word_addr + 32'd4;
      end
      unique case (state)
        LDR_IDLE: begin
          state     <= LDR_RECV;
          rx_ready  <= 1'b1;
          byte_cnt  <= '0;
          word_addr <= BASE_ADDR;
          trunc_o   <= 1'b0;
          pkt_len_o <= '0;
        end
        LDR_RECV: begin
          if (acc) begin
            if (keep) begin
              byte_cnt <= byte_cnt + 16'd1;
            end else begin
              trunc_o <= 1'b1;
            end
            if (bus.rx_last_i) begin
              state    <= LDR_START;
              rx_ready <= 1'b0;
            end
          end
        end
        LDR_START: begin
          state        <= LDR_WAIT;
          start_o      <= 1'b1;
          start_addr_o <= BASE_ADDR;
          pkt_len_o    <= byte_cnt;
        end
        LDR_WAIT: begin
          if (exec_done_i) begin
            state <= LDR_IDLE;
          end
        end
        default: state <= LDR_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_packet_loader.sv
// Scoreboard bench for packet_loader: random packets vs. a byte-image model.
// Honours PKT_CSUM_CLEAR_EN in the model when the build defines it.
module tb_packet_loader;
  import packet_loader_pkg::*;

  localparam int    MAXB = 32;
  localparam addr_t BASE = 32'd64;

  typedef struct {
    addr_t      addr;
    logic [3:0] sel;
    data_t      data;
  } wr_t;

  typedef struct {
    int   len;
    logic trunc;
  } st_t;

  logic     clk = 1'b0;
  logic     rst = 1'b1;
  logic     start_o;
  addr_t    start_addr_o;
  pkt_len_t pkt_len_o;
  logic     trunc_o;
  logic     exec_done_i = 1'b0;

  always #5 clk = ~clk;

  packet_loader_if bus ();

  packet_loader #(
    .BASE_ADDR (BASE),
    .MAX_BYTES (16'(MAXB))
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .start_o      (start_o),
    .start_addr_o (start_addr_o),
    .pkt_len_o    (pkt_len_o),
    .trunc_o      (trunc_o),
    .exec_done_i  (exec_done_i)
  );

  int         n_cmp = 0;
  int         n_bad = 0;
  int         starts_seen = 0;
  int         starts_exp = 0;
  time        t_acc = 0;
  wr_t        exp_wr[$];
  st_t        exp_st[$];
  logic [7:0] pkt[$];
  wr_t        mon_w;
  st_t        mon_s;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: stored image is the first min(len,MAXB) bytes, big-endian words
  task automatic model_push();
    int   n;
    int   st;
    logic [7:0] b;
    wr_t  w;
    st_t  s;
    n  = pkt.size();
    st = (n > MAXB) ? MAXB : n;
    for (int wi = 0; wi * 4 < st; wi++) begin
      w.addr = BASE + 32'(wi * 4);
      w.sel  = 4'd0;
      w.data = '0;
      for (int j = 0; j < 4; j++) begin
        if (wi * 4 + j < st) begin
          b = pkt[wi * 4 + j];
`ifdef PKT_CSUM_CLEAR_EN
          if (wi * 4 + j == 24 || wi * 4 + j == 25) b = 8'h00;
`endif
          w.data[31 - 8 * j -: 8] = b;
          w.sel[3 - j]            = 1'b1;
        end
      end
      exp_wr.push_back(w);
    end
    s.len   = st;
    s.trunc = (n > MAXB);
    exp_st.push_back(s);
    starts_exp++;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.sram_ce_o) begin
        if (exp_wr.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sram_unexpected: got write @%h, expected none",
                   bus.sram_addr_o);
        end else begin
          mon_w = exp_wr.pop_front();
          check("sram_addr", bus.sram_addr_o, mon_w.addr);
          check("sram_sel", 32'(bus.sram_sel_o), 32'(mon_w.sel));
          check("sram_data", bus.sram_data_o, mon_w.data);
          check("sram_we", 32'(bus.sram_we_o), 32'd1);
        end
      end
      if (start_o) begin
        starts_seen++;
        check("start_lat", 32'($time - t_acc), 32'd15);
        if (exp_st.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL start_unexpected: got start_o=1, expected none");
        end else begin
          mon_s = exp_st.pop_front();
          check("start_addr", start_addr_o, BASE);
          check("pkt_len", 32'(pkt_len_o), 32'(mon_s.len));
          check("trunc", 32'(trunc_o), 32'(mon_s.trunc));
        end
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(bus.rx_ready_o), 32'd0);
    check({tag, "_ce"}, 32'(bus.sram_ce_o), 32'd0);
    check({tag, "_we"}, 32'(bus.sram_we_o), 32'd0);
    check({tag, "_addr"}, bus.sram_addr_o, 32'd0);
    check({tag, "_sel"}, 32'(bus.sram_sel_o), 32'd0);
    check({tag, "_data"}, bus.sram_data_o, 32'd0);
    check({tag, "_start"}, 32'(start_o), 32'd0);
    check({tag, "_saddr"}, start_addr_o, 32'd0);
    check({tag, "_len"}, 32'(pkt_len_o), 32'd0);
    check({tag, "_trunc"}, 32'(trunc_o), 32'd0);
  endtask

  task automatic wait_ready();
    int w = 0;
    while (bus.rx_ready_o !== 1'b1 && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("ready_rise", 32'(bus.rx_ready_o), 32'd1);
  endtask

  task automatic send_pkt();
    int n;
    int w;
    n = pkt.size();
    model_push();
    wait_ready();
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(3) == 0) begin
        bus.rx_valid_i = 1'b0;
        exec_done_i    = 1'($urandom_range(1));
        @(negedge clk);
        #1;
      end
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = pkt[i];
      bus.rx_last_i  = (i == n - 1);
      exec_done_i    = 1'($urandom_range(1));
      check("ready_recv", 32'(bus.rx_ready_o), 32'd1);
      @(posedge clk);
      t_acc = $time;
      @(negedge clk);
      #1;
    end
    bus.rx_valid_i = 1'b0;
    bus.rx_last_i  = 1'b0;
    exec_done_i    = 1'b0;
    w = 0;
    while (starts_seen < starts_exp && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    check("start_seen", 32'(starts_seen), 32'(starts_exp));
    bus.rx_valid_i = 1'b1;
    bus.rx_data_i  = 8'($urandom);
    repeat ($urandom_range(1, 4)) begin
      check("ready_wait", 32'(bus.rx_ready_o), 32'd0);
      @(negedge clk);
      #1;
    end
    bus.rx_valid_i = 1'b0;
    exec_done_i    = 1'b1;
    @(negedge clk);
    #1;
    exec_done_i = 1'b0;
    check("ready_idle", 32'(bus.rx_ready_o), 32'd0);
    @(negedge clk);
    #1;
    check("ready_plus2", 32'(bus.rx_ready_o), 32'd1);
  endtask

  task automatic fill_seq(input int n, input logic [7:0] first);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(first + 8'(i));
  endtask

  task automatic fill_rand(input int n);
    pkt.delete();
    for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
  endtask

  initial begin
    int w;
    bus.rx_valid_i = 1'b0;
    bus.rx_data_i  = 8'h00;
    bus.rx_last_i  = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;

    fill_seq(8, 8'h01);
    send_pkt();
    pkt.delete();
    pkt.push_back(8'hAA);
    pkt.push_back(8'hBB);
    pkt.push_back(8'hCC);
    pkt.push_back(8'hDD);
    pkt.push_back(8'hEE);
    send_pkt();
    fill_seq(60, 8'h10);
    send_pkt();
    fill_seq(1, 8'h5A);
    send_pkt();
    fill_seq(MAXB, 8'h80);
    send_pkt();
    fill_seq(MAXB + 1, 8'h40);
    send_pkt();
    fill_rand(40);
    send_pkt();

    wait_ready();
    for (int i = 0; i < 3; i++) begin
      bus.rx_valid_i = 1'b1;
      bus.rx_data_i  = 8'(8'hC0 + i);
      bus.rx_last_i  = 1'b0;
      @(negedge clk);
      #1;
    end
    rst            = 1'b1;
    bus.rx_valid_i = 1'b0;
    @(negedge clk);
    #1;
    check_reset_outputs("rst_mid");
    rst = 1'b0;

    for (int p = 0; p < 25; p++) begin
      fill_rand($urandom_range(1, 40));
      send_pkt();
    end

    w = 0;
    while ((exp_wr.size() != 0 || exp_st.size() != 0) && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("wr_q_empty", 32'(exp_wr.size()), 32'd0);
    check("st_q_empty", 32'(exp_st.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
